// File: rtl/tag_reply_check_pkg.sv
// Shared receive-path definitions for the tag reply checker.
// Holds the CRC-16 constants (preset, polynomial, good residue), the
// reply classification encoding, the checker state encoding and a
// single-bit CRC-16 update helper shared by the serial CRC and the top.
// No ports: imported with tag_reply_check_pkg::*.
package tag_reply_check_pkg;

  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    REPLY_ERR  = 2'd0,
    REPLY_RN16 = 2'd1,
    REPLY_CRC  = 2'd2
  } reply_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One MSB-first CRC-16 step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tag_reply_check_if.sv
// Decoder-to-checker-to-controller bundle.
// Decoder side:    tag_data (bit buffer, bit 0 newest), tag_finish (end-of-reply
//                  strobe), tag_data_number (bits received incl. dummy bit).
// Controller side: reply_valid (one-cycle result strobe), reply_type, crc_ok,
//                  dummy_ok, payload_len, payload (right-justified), busy, overrun.
// The master modport drives the decoder side and observes the results; the
// slave modport is the checker itself.
interface tag_reply_check_if #(
  parameter int MAX_BITS = 256
);

  logic [MAX_BITS-1:0] tag_data;
  logic                tag_finish;
  logic [15:0]         tag_data_number;

  logic                reply_valid;
  logic [1:0]          reply_type;
  logic                crc_ok;
  logic                dummy_ok;
  logic [7:0]          payload_len;
  logic [MAX_BITS-1:0] payload;
  logic                busy;
  logic                overrun;

  modport master (
    output tag_data, tag_finish, tag_data_number,
    input  reply_valid, reply_type, crc_ok, dummy_ok, payload_len, payload, busy, overrun
  );

  modport slave (
    input  tag_data, tag_finish, tag_data_number,
    output reply_valid, reply_type, crc_ok, dummy_ok, payload_len, payload, busy, overrun
  );

endinterface

// File: rtl/tag_reply_check_crc16_serial.sv
// Serial CRC-16 engine, one bit per clock, MSB first.
// Ports: clk_i, rst_ni (async active-low), init_i (load preset, wins over en_i),
//        en_i (fold bit_i into the register), bit_i, crc_o (current register).
// Also intended for reuse by the transmit path.
module tag_reply_check_crc16_serial
  import tag_reply_check_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC16_PRESET;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC16_PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/tag_reply_check.sv
// Post-decoder reply checker.
// On each end-of-reply strobe it snapshots the decoder buffer, drops the
// trailing FM0 dummy bit, classifies the reply (RN16 / CRC-protected / length
// error), walks the bits oldest-first one per cycle through a serial CRC-16
// and a payload shift register, then presents the result with a one-cycle
// reply_valid. Results hold until the next result strobe.
// Ports: clk, reset (async active-low), bus (slave side of tag_reply_check_if).
module tag_reply_check
  import tag_reply_check_pkg::*;
#(
  parameter int          MAX_BITS    = 256,
  parameter int          RN16_BITS   = 16,
  parameter logic [15:0] CRC_RESIDUE = CRC16_RESIDUE
) (
  input  logic             clk,
  input  logic             reset,
  tag_reply_check_if.slave bus
);

  localparam int          IDX_W      = $clog2(MAX_BITS);
  localparam logic [15:0] MAX_BITS_W = 16'(MAX_BITS);
  localparam logic [15:0] RN16_W     = 16'(RN16_BITS);
  localparam logic [15:0] CRC_MIN_N  = 16'd32;
  localparam logic [15:0] CRC_W      = 16'd16;

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] buf_q;
  logic [8:0]          idx_q;
  logic [8:0]          thr_q;
  reply_type_e         kind_q;
  logic [7:0]          len_q;
  logic                dummy_q;
  logic [MAX_BITS-1:0] sr_q, sr_d;

  reply_type_e         rtype_q;
  logic                crc_ok_q;
  logic                dummy_ok_q;
  logic [7:0]          plen_q;
  logic [MAX_BITS-1:0] payload_q;
  logic                overrun_q;

  logic [15:0]         n_bits;
  reply_type_e         cls_kind;
  logic [8:0]          cls_thr;
  logic [7:0]          cls_len;
  logic                accept;
  logic                shifting;
  logic                last_bit;
  logic                cur_bit;
  logic                take_bit;
  logic [15:0]         crc_q;

  // Classify the incoming reply. cls_thr is the idx value at or below which
  // bits stop entering the payload (the CRC field for CRC replies).
  always_comb begin
    n_bits   = bus.tag_data_number - 16'd1;
    cls_kind = REPLY_ERR;
    cls_thr  = '0;
    cls_len  = '0;
    if (bus.tag_data_number == 16'd0 || bus.tag_data_number > MAX_BITS_W) begin
      cls_kind = REPLY_ERR;
    end else if (n_bits == RN16_W) begin
      cls_kind = REPLY_RN16;
      cls_len  = 8'(RN16_BITS);
    end else if (n_bits >= CRC_MIN_N) begin
      cls_kind = REPLY_CRC;
      cls_len  = 8'(n_bits - CRC_W);
      cls_thr  = 9'(CRC_W);
    end
  end

  assign shifting = (state_q == ST_SHIFT);
  assign last_bit = shifting && (idx_q == 9'd1);
  assign cur_bit  = buf_q[idx_q[IDX_W-1:0]];
  assign take_bit = (idx_q > thr_q);
  assign sr_d     = take_bit ? {sr_q[MAX_BITS-2:0], cur_bit} : sr_q;

  // Next-state logic; a strobe is only taken in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tag_finish) begin
          accept  = 1'b1;
          state_d = (cls_kind == REPLY_ERR) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot on accept, then walk idx down from N to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      idx_q   <= '0;
      thr_q   <= '0;
      kind_q  <= REPLY_ERR;
      len_q   <= '0;
      dummy_q <= 1'b0;
      sr_q    <= '0;
    end else if (accept) begin
      buf_q   <= bus.tag_data;
      idx_q   <= 9'(n_bits);
      thr_q   <= cls_thr;
      kind_q  <= cls_kind;
      len_q   <= cls_len;
      dummy_q <= bus.tag_data[0];
      sr_q    <= '0;
    end else if (shifting) begin
      idx_q <= idx_q - 9'd1;
      sr_q  <= sr_d;
    end
  end

  tag_reply_check_crc16_serial u_crc (
    .clk_i  (clk),
    .rst_ni (reset),
    .init_i (accept),
    .en_i   (shifting),
    .bit_i  (cur_bit),
    .crc_o  (crc_q)
  );

  // Results load on the edge entering DONE, so the final bit is folded in
  // here rather than waiting for the CRC register to catch up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rtype_q    <= REPLY_ERR;
      crc_ok_q   <= 1'b0;
      dummy_ok_q <= 1'b0;
      plen_q     <= '0;
      payload_q  <= '0;
    end else if (accept && cls_kind == REPLY_ERR) begin
      rtype_q    <= REPLY_ERR;
      crc_ok_q   <= 1'b0;
      dummy_ok_q <= bus.tag_data[0];
      plen_q     <= '0;
      payload_q  <= '0;
    end else if (last_bit) begin
      rtype_q    <= kind_q;
      crc_ok_q   <= (kind_q == REPLY_CRC) && (crc16_step(crc_q, cur_bit) == CRC_RESIDUE);
      dummy_ok_q <= dummy_q;
      plen_q     <= len_q;
      payload_q  <= sr_d;
    end
  end

  // A strobe outside IDLE is dropped and flagged one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.tag_finish && (state_q != ST_IDLE);
    end
  end

  assign bus.reply_valid = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.reply_type  = rtype_q;
  assign bus.crc_ok      = crc_ok_q;
  assign bus.dummy_ok    = dummy_ok_q;
  assign bus.payload_len = plen_q;
  assign bus.payload     = payload_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_tag_reply_check.sv
// Self-checking bench for tag_reply_check: directed replies (RN16, good and
// bad CRC, length errors, overrun, mid-check reset) followed by randomized
// replies compared against a frame-level reference model.
module tb_tag_reply_check;

  localparam int MAX_BITS = 256;
  localparam int TIMEOUT  = 600;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tag_reply_check_if #(.MAX_BITS(MAX_BITS)) bus ();

  tag_reply_check #(
    .MAX_BITS    (MAX_BITS),
    .RN16_BITS   (16),
    .CRC_RESIDUE (16'h1D0F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a reply for one cycle; returns in cycle T+1.
  task automatic applyStimulus(input logic [255:0] data, input logic [15:0] num);
    bus.tag_data        = data;
    bus.tag_data_number = num;
    bus.tag_finish      = 1'b1;
    step();
    bus.tag_finish      = 1'b0;
  endtask

  task automatic waitValid(input int startCycle, output int lat);
    lat = startCycle;
    while (bus.reply_valid !== 1'b1 && lat < TIMEOUT) begin
      step();
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expType, input logic expOk,
                             input logic [7:0] expLen, input logic [255:0] expPay,
                             input logic expDummy, input int expLat, input int lat);
    checkValue({tag, "_latency"}, 256'(lat), 256'(expLat));
    checkValue({tag, "_type"}, bus.reply_type, expType);
    checkValue({tag, "_crc_ok"}, bus.crc_ok, expOk);
    checkValue({tag, "_len"}, bus.payload_len, expLen);
    checkValue({tag, "_payload"}, bus.payload, expPay);
    checkValue({tag, "_dummy"}, bus.dummy_ok, expDummy);
    checkValue({tag, "_busy"}, bus.busy, 1'b1);
  endtask

  function automatic logic [255:0] maskBits(input int n);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // CRC-16 (preset FFFF, poly 1021, MSB first) over the payload field
  // data[len+16:17], oldest bit first.
  function automatic logic [15:0] crcOfPayload(input logic [255:0] data, input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = len + 16; i >= 17; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Frame-level reference: a good CRC reply carries the complement of the
  // payload's CRC in the 16 bits just above the dummy bit.
  function automatic void modelReply(input logic [255:0] data, input int num,
                                     output logic [1:0] eType, output logic eOk,
                                     output logic [7:0] eLen, output logic [255:0] ePay,
                                     output logic eDummy, output int eLat);
    int n;
    n      = num - 1;
    eDummy = data[0];
    eType  = 2'd0;
    eOk    = 1'b0;
    eLen   = '0;
    ePay   = '0;
    eLat   = 1;
    if (num >= 1 && num <= MAX_BITS) begin
      if (n == 16) begin
        eType = 2'd1;
        eLen  = 8'd16;
        ePay  = (data >> 1) & maskBits(16);
        eLat  = n + 1;
      end else if (n >= 32) begin
        eType = 2'd2;
        eLen  = 8'(n - 16);
        ePay  = (data >> 17) & maskBits(n - 16);
        eOk   = (data[16:1] == ~crcOfPayload(data, n - 16));
        eLat  = n + 1;
      end
    end
  endfunction

  initial begin
    logic [255:0] d;
    logic [255:0] goodData;
    logic [255:0] goodPay;
    logic [255:0] ePay;
    logic [1:0]   eType;
    logic         eOk;
    logic         eDummy;
    logic [7:0]   eLen;
    int           eLat;
    int           lat;
    int           num;
    int           plen;
    int           gap;
    int           extra;
    int           errLens[3];

    reset               = 1'b0;
    bus.tag_data        = '0;
    bus.tag_finish      = 1'b0;
    bus.tag_data_number = '0;

    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_valid", bus.reply_valid, 1'b0);
    checkValue("reset_busy", bus.busy, 1'b0);
    checkValue("reset_type", bus.reply_type, 2'd0);
    checkValue("reset_len", bus.payload_len, 8'd0);
    checkValue("reset_payload", bus.payload, '0);
    checkValue("reset_overrun", bus.overrun, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();

    $display("[TB] RN16 reply");
    d = '0;
    d[16:0] = {16'hA5C3, 1'b1};
    applyStimulus(d, 16'd17);
    checkValue("rn16_busy_start", bus.busy, 1'b1);
    waitValid(1, lat);
    checkOutput("rn16", 2'd1, 1'b0, 8'd16, 256'hA5C3, 1'b1, 17, lat);
    step();
    checkValue("rn16_valid_pulse", bus.reply_valid, 1'b0);
    checkValue("rn16_busy_end", bus.busy, 1'b0);
    checkValue("rn16_hold", bus.payload, 256'hA5C3);

    $display("[TB] good CRC reply");
    goodData = '0;
    goodData[88:0] = {72'h313233343536373839, 16'hD64E, 1'b1};
    goodPay = 256'h313233343536373839;
    applyStimulus(goodData, 16'd89);
    waitValid(1, lat);
    checkOutput("crc_good", 2'd2, 1'b1, 8'd72, goodPay, 1'b1, 89, lat);
    step();

    $display("[TB] bad CRC reply");
    d = goodData;
    d[40] = ~d[40];
    applyStimulus(d, 16'd89);
    waitValid(1, lat);
    checkOutput("crc_bad", 2'd2, 1'b0, 8'd72, goodPay ^ (256'd1 << 23), 1'b1, 89, lat);
    step();

    $display("[TB] length errors");
    errLens = '{0, 20, 300};
    for (int k = 0; k < 3; k++) begin
      d = {8{$urandom()}};
      applyStimulus(d, 16'(errLens[k]));
      waitValid(1, lat);
      checkOutput($sformatf("len_err_%0d", errLens[k]), 2'd0, 1'b0, 8'd0, '0, d[0], 1, lat);
      step();
    end

    $display("[TB] overrun during CRC check");
    applyStimulus(goodData, 16'd89);
    repeat (4) step();
    bus.tag_data        = {8{$urandom()}};
    bus.tag_data_number = 16'd17;
    bus.tag_finish      = 1'b1;
    step();
    bus.tag_finish = 1'b0;
    checkValue("overrun_pulse", bus.overrun, 1'b1);
    step();
    checkValue("overrun_clear", bus.overrun, 1'b0);
    waitValid(7, lat);
    checkOutput("overrun_first", 2'd2, 1'b1, 8'd72, goodPay, 1'b1, 89, lat);
    step();
    extra = 0;
    repeat (120) begin
      if (bus.reply_valid === 1'b1) extra++;
      step();
    end
    checkValue("overrun_dropped", 256'(extra), 256'd0);

    $display("[TB] reset mid-check");
    applyStimulus(goodData, 16'd89);
    repeat (29) step();
    #2;
    reset = 1'b0;
    #1;
    checkValue("midrst_valid", bus.reply_valid, 1'b0);
    checkValue("midrst_busy", bus.busy, 1'b0);
    checkValue("midrst_type", bus.reply_type, 2'd0);
    checkValue("midrst_crc_ok", bus.crc_ok, 1'b0);
    checkValue("midrst_len", bus.payload_len, 8'd0);
    checkValue("midrst_payload", bus.payload, '0);
    checkValue("midrst_dummy", bus.dummy_ok, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    extra = 0;
    repeat (100) begin
      if (bus.reply_valid === 1'b1) extra++;
      step();
    end
    checkValue("midrst_no_valid", 256'(extra), 256'd0);
    d = '0;
    d[16:0] = {16'h3C5A, 1'b1};
    applyStimulus(d, 16'd17);
    waitValid(1, lat);
    checkOutput("midrst_rn16", 2'd1, 1'b0, 8'd16, 256'h3C5A, 1'b1, 17, lat);
    step();

    $display("[TB] randomized replies");
    for (int t = 0; t < 24; t++) begin
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2: num = 17;
        3, 4, 5, 6, 7: begin
          case ($urandom_range(0, 5))
            0:       plen = 16;
            1:       plen = 239;
            default: plen = int'($urandom_range(17, 238));
          endcase
          num = plen + 17;
          if ($urandom_range(0, 1) == 1) d[16:1] = ~crcOfPayload(d, plen);
        end
        default: begin
          num = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : int'($urandom_range(257, 2000));
          if (num == 17) num = 18;
        end
      endcase
      modelReply(d, num, eType, eOk, eLen, ePay, eDummy, eLat);
      applyStimulus(d, 16'(num));
      checkValue($sformatf("rand%0d_no_overrun", t), bus.overrun, 1'b0);
      waitValid(1, lat);
      checkOutput($sformatf("rand%0d_n%0d", t, num), eType, eOk, eLen, ePay, eDummy, eLat, lat);
      step();
      checkValue($sformatf("rand%0d_valid_pulse", t), bus.reply_valid, 1'b0);
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_reply_check.md
# tag_reply_check

Post-decoder stage of the reader receive path. It sits directly downstream of the FM0 pulse counter/decoder and consumes its 256-bit bit buffer, bit count and end-of-reply strobe. On each end-of-reply strobe it snapshots the buffer, strips the trailing FM0 dummy bit and classifies the reply as RN16 or CRC-protected. It checks CRC-16 serially, one bit per cycle, and presents the right-justified payload with a one-cycle valid strobe to the reader controller.

## Interface
- `MAX_BITS`, default 256: width of the decoder bit buffer.
- `RN16_BITS`, default 16: payload length of a reply carried without CRC.
- `CRC_RESIDUE`, default 16'h1D0F: good-CRC residue (preset 16'hFFFF, poly 16'h1021, MSB first).
- `clk` in, 1: receive clock, same clock as the decoder.
- `reset` in, 1: **one clock; reset is asynchronous and active-low.**
- `tag_data` in, MAX_BITS: decoder buffer. Bit 0 is the newest bit; bit `tag_data_number-1` is the oldest.
- `tag_finish` in, 1: one-cycle end-of-reply strobe from the decoder.
- `tag_data_number` in, 16: bits received, including the dummy bit.
- `reply_valid` out, 1: one-cycle result strobe.
- `reply_type` out, 2: 0 = error, 1 = RN16, 2 = CRC reply.
- `crc_ok` out, 1: residue matched. Meaningful only when `reply_type` is 2.
- `dummy_ok` out, 1: the last received bit was 1.
- `payload_len` out, 8: payload bits, excluding CRC and dummy.
- `payload` out, MAX_BITS: payload, right-justified, oldest bit at index `payload_len-1`, zero above.
- `busy` out, 1: a check is in progress.
- `overrun` out, 1: one-cycle pulse when `tag_finish` arrives while busy.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE. `reset` low mid-check aborts immediately, with no `reply_valid`.
- **IDLE.** On `tag_finish`, latch `tag_data` into `buf`, set `N = tag_data_number - 1` and `dummy_ok = tag_data[0]`, then classify:
  - `tag_data_number` is 0 or greater than MAX_BITS: length error, go to DONE.
  - N == RN16_BITS: RN16. Go to SHIFT with CRC disabled.
  - N >= 32: CRC reply. Go to SHIFT with CRC enabled. `payload_len = N - 16`.
  - Any other N: length error, go to DONE.
- **SHIFT.** An index counter `idx` starts at N and decrements once per cycle, stopping after the cycle with `idx == 1`. So exactly N cycles. Each cycle:
  - Bit `b = buf[idx]`.
  - CRC update: `fb = crc[15] ^ b`; `crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0)`. `crc` starts at 16'hFFFF.
  - While fewer than `payload_len` bits have been taken, `b` shifts into `payload_sr` from the LSB side.
- **DONE.** Drive the results:
  - `reply_valid` = 1 for one cycle.
  - `crc_ok = (crc == CRC_RESIDUE)`, forced to 0 for RN16 and error replies.
  - `payload = payload_sr`. For an error reply, `payload` and `payload_len` are 0.
  - Return to IDLE.
- **Holding.** Outputs other than the strobes hold their value until the next DONE.
- **Overrun.** A `tag_finish` in SHIFT or DONE is dropped. It pulses `overrun` in the following cycle. The current check continues unaffected.
- **Back-to-back.** A `tag_finish` in the same cycle the block returns to IDLE is accepted.
- **Widths.** `idx` is 9 bits. The index `buf[idx]` is never out of range after classification.

## Timing
- `tag_finish` at cycle T.
- SHIFT occupies T+1 through T+N.
- `reply_valid` is high in cycle T+N+1, so latency is N+1 cycles.
- Error replies: `reply_valid` is high at T+1.
- `busy` is high from T+1 until the `reply_valid` cycle inclusive.
- The next accepted `tag_finish` is at cycle T+N+2 or later.
- Throughput: a 256-bit reply takes 256 cycles, about 40 µs at 6.4 MHz. This is far shorter than the minimum inter-reply gap.

## Structure
- A shared receive-path package holds:
  - the CRC-16 preset, polynomial and residue constants;
  - the `reply_type` encoding (ERR, RN16, CRC);
  - the state encoding (IDLE, SHIFT, DONE).
- One natural sub-module is `crc16_serial`, a 1-bit-per-cycle CRC with `init` and `en` inputs, to be reused by the transmit path.

## Test plan
- RN16: `tag_data_number` = 17, `tag_data[16:0]` = {16'hA5C3, 1'b1}.
  - Response: `reply_type` 1, `payload` 16'hA5C3, `payload_len` 16, `dummy_ok` 1, `crc_ok` 0, `reply_valid` at T+17.
- Good CRC: payload ASCII "123456789" (72 bits), then the transmitted CRC 16'hD64E, then the dummy 1. `tag_data_number` = 89.
  - Response: `reply_type` 2, `crc_ok` 1, `payload_len` 72, `payload` = 72'h313233343536373839, `reply_valid` at T+89.
- Bad CRC: the same frame with buffer bit 40 flipped.
  - Response: `crc_ok` 0, `reply_type` 2, `payload` reflects the flipped bit.
- Length errors: `tag_data_number` set to 0, to 20 and to 300, one per run.
  - Response: each gives `reply_valid` at T+1, `reply_type` 0, `payload_len` 0.
- Overrun: a second `tag_finish` at T+5 during the 89-bit check.
  - Response: `overrun` pulse at T+6, the first result is still correct at T+89, and the second reply is not reported.
- Reset mid-check: assert `reset` at T+30.
  - Response: all outputs go to 0 asynchronously, no `reply_valid`. A fresh RN16 after release decodes correctly.
